// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational ALU between two requesters.
// Each operation takes three cycles: accept, execute, respond.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_op1,
    input  logic [WIDTH-1:0] req0_op2,
    input  logic [2:0]       req0_ctrl,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_result,
    output logic             resp0_zero,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_op1,
    input  logic [WIDTH-1:0] req1_op2,
    input  logic [2:0]       req1_ctrl,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_result,
    output logic             resp1_zero,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic             last_grant;
    logic             id_q;
    logic [WIDTH-1:0] op1_q;
    logic [WIDTH-1:0] op2_q;
    logic [2:0]       ctrl_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             grant_valid;
    logic             grant_id;
    logic             resp_done;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant;
            end else if (req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    assign req0_ready = grant_valid && !grant_id;
    assign req1_ready = grant_valid && grant_id;
    assign resp_done  = id_q ? resp1_ready : resp0_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            id_q        <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            ctrl_q      <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        id_q   <= grant_id;
                        op1_q  <= grant_id ? req1_op1  : req0_op1;
                        op2_q  <= grant_id ? req1_op2  : req0_op2;
                        ctrl_q <= grant_id ? req1_ctrl : req0_ctrl;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    result_q    <= alu_result;
                    zero_q      <= alu_zero;
                    resp0_valid <= !id_q;
                    resp1_valid <= id_q;
                    state       <= RESP;
                end
                RESP: begin
                    if (resp_done) begin
                        last_grant  <= id_q;
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The ALU sees the operand registers permanently; they simply hold while idle.
    assign alu_op1      = op1_q;
    assign alu_op2      = op2_q;
    assign alu_ctrl     = ctrl_q;
    assign resp0_result = result_q;
    assign resp0_zero   = zero_q;
    assign resp1_result = result_q;
    assign resp1_zero   = zero_q;

endmodule
